trap_controller: RTL and testbench
==================================

TRAP_CONTROLLER -- requirements
Module: trap_controller

Interface
REQ-001 SHALL have parameter: XLEN, 32, datapath/PC width.
REQ-002 SHALL have ports: clk  in  1  clock, all state on rising edge.
REQ-003 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: instr_valid_i  in  1  instruction at pc_i reaches commit this cycle.
REQ-005 SHALL have ports: pc_i  in  XLEN  PC of the committing instruction.
REQ-006 SHALL have ports: instr_i  in  32  raw bits of the committing instruction.
REQ-007 SHALL have ports: instr_misaligned_i, illegal_instr_i, ebreak_i, ecall_i, load_misaligned_i, store_misaligned_i  in  1 each  exception flags of the committing instruction.
REQ-008 SHALL have ports: branch_target_i  in  XLEN  faulting fetch target; mem_addr_i  in  XLEN  load/store effective address.
REQ-009 SHALL have ports: mret_i  in  1  committing instruction is MRET.
REQ-010 SHALL have ports: mtime_exc_i  in  1  enabled, pending timer interrupt from the CSR unit.
REQ-011 SHALL have ports: mtvec_i, mepc_i  in  XLEN  current CSR values.
REQ-012 SHALL have ports: jumpingToMtvec_o  out  1; excCause_o, trapInfo_o, trapPc_o  out  32  trap record to the CSR unit.
REQ-013 SHALL have ports: squash_o  out  1  kill writeback/memory side effects of the committing instruction.
REQ-014 SHALL have ports: stall_o  out  1  freeze fetch/commit.
REQ-015 SHALL have ports: redirect_valid_o  out  1; redirect_pc_o  out  XLEN; redirect_ready_i  in  1  PC redirect handshake to fetch.
REQ-016 SHALL have ports: mret_o  out  1  one-cycle MRET retire pulse.

Function
REQ-017 SHALL implement an FSM with states IDLE, COMMIT, REDIRECT, MRET_REDIRECT.
REQ-018 SHALL evaluate events only in IDLE with instr_valid_i=1; in all other states inputs SHALL be ignored and stall_o=1.
REQ-019 SHALL use this priority (highest first): mtime_exc_i, instr_misaligned_i, illegal_instr_i, ebreak_i, ecall_i, load_misaligned_i, store_misaligned_i, then mret_i.
REQ-020 SHALL use cause/trapInfo per event as follows.
- timer: 0x80000007 / 0.
- instr misaligned: 0 / branch_target_i.
- illegal: 2 / instr_i.
- ebreak: 3 / pc_i.
- ecall: 11 / 0.
- load misaligned: 4 / mem_addr_i.
- store misaligned: 6 / mem_addr_i.
REQ-021 On a trap event in cycle N: squash_o=1 and stall_o=1 combinationally in N; cause, info and pc_i SHALL be registered; next state COMMIT.
REQ-022 In COMMIT (cycle N+1): jumpingToMtvec_o=1 for exactly one cycle, excCause_o/trapInfo_o/trapPc_o hold the registered record; next state REDIRECT.
REQ-023 In REDIRECT: redirect_valid_o=1 and redirect_pc_o={mtvec_i[XLEN-1:2],2'b00}, held stable until the cycle redirect_ready_i=1; the next state is then IDLE.
REQ-024 On MRET with no trap event in cycle N: mret_o=1 and stall_o=1 in N, squash_o=0; mepc_i SHALL be latched; next state MRET_REDIRECT.
REQ-025 In MRET_REDIRECT: redirect_valid_o=1 and redirect_pc_o=latched mepc, with the same handshake as REQ-023.
REQ-026 jumpingToMtvec_o, squash_o and mret_o SHALL never be asserted outside the cycles stated above.
REQ-027 Outputs excCause_o/trapInfo_o/trapPc_o SHALL hold the last record between traps.
REQ-028 A timer interrupt arriving in a non-IDLE state SHALL be taken at the first IDLE cycle with instr_valid_i=1 if still asserted; it SHALL NOT be queued internally.
REQ-029 With instr_valid_i=0 in IDLE, no event SHALL be taken and stall_o=0.

Reset
REQ-030 rst=1 SHALL asynchronously force IDLE and drive all outputs to 0, including mid-trap or mid-handshake; the registered record SHALL be cleared to 0.
REQ-031 The first event SHALL be evaluated on the first rising edge after rst deasserts.

Verification
REQ-032 Illegal instr 0xFFFFFFFF at pc 0x100, mtvec_i=0x201 -> squash in N; cycle N+1 jumpingToMtvec=1, cause 2, info 0xFFFFFFFF, trapPc 0x100; redirect_pc 0x200.
REQ-033 mtime_exc_i with ecall_i at pc 0x40 -> cause 0x80000007, info 0, trapPc 0x40.
REQ-034 MRET with mepc_i=0x84, redirect_ready_i low 3 cycles -> mret_o pulse; redirect_valid/pc 0x84 stable 4 cycles; IDLE afterwards.
REQ-035 load_misaligned_i with store_misaligned_i, mem_addr_i=0x1003 -> cause 4, info 0x1003.
REQ-036 rst pulse during REDIRECT -> all outputs 0 immediately; a new event after release is handled normally.

Source files
------------

// File: rtl/trap_controller.sv
// Commit-stage trap and MRET sequencer: prioritises exceptions and interrupts, hands the
// trap record to the CSR unit and runs the PC redirect handshake towards fetch.
module trap_controller #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     instr_i,
    input  logic            instr_misaligned_i,
    input  logic            illegal_instr_i,
    input  logic            ebreak_i,
    input  logic            ecall_i,
    input  logic            load_misaligned_i,
    input  logic            store_misaligned_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic [XLEN-1:0] mem_addr_i,
    input  logic            mret_i,
    input  logic            mtime_exc_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    output logic            jumpingToMtvec_o,
    output logic [31:0]     excCause_o,
    output logic [31:0]     trapInfo_o,
    output logic [31:0]     trapPc_o,
    output logic            squash_o,
    output logic            stall_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    input  logic            redirect_ready_i,
    output logic            mret_o
);

    typedef enum logic [1:0] {
        StIdle,
        StCommit,
        StRedirect,
        StMretRedirect
    } state_e;

    localparam logic [31:0] CauseTimer       = 32'h8000_0007;
    localparam logic [31:0] CauseInstrMisal  = 32'd0;
    localparam logic [31:0] CauseIllegal     = 32'd2;
    localparam logic [31:0] CauseEbreak      = 32'd3;
    localparam logic [31:0] CauseEcall       = 32'd11;
    localparam logic [31:0] CauseLoadMisal   = 32'd4;
    localparam logic [31:0] CauseStoreMisal  = 32'd6;

    state_e          state_q, state_d;
    logic [31:0]     cause_q, cause_d;
    logic [31:0]     info_q, info_d;
    logic [31:0]     tpc_q, tpc_d;
    logic [XLEN-1:0] mepc_q, mepc_d;

    logic            trap_event;
    logic [31:0]     event_cause;
    logic [31:0]     event_info;
    logic [XLEN-1:0] mtvec_aligned;

    assign mtvec_aligned = {mtvec_i[XLEN-1:2], 2'b00};

    // Fixed-priority event decode; timer interrupt outranks every synchronous exception.
    always_comb begin
        trap_event  = 1'b1;
        event_cause = 32'd0;
        event_info  = 32'd0;
        if (mtime_exc_i) begin
            event_cause = CauseTimer;
        end else if (instr_misaligned_i) begin
            event_cause = CauseInstrMisal;
            event_info  = 32'(branch_target_i);
        end else if (illegal_instr_i) begin
            event_cause = CauseIllegal;
            event_info  = instr_i;
        end else if (ebreak_i) begin
            event_cause = CauseEbreak;
            event_info  = 32'(pc_i);
        end else if (ecall_i) begin
            event_cause = CauseEcall;
        end else if (load_misaligned_i) begin
            event_cause = CauseLoadMisal;
            event_info  = 32'(mem_addr_i);
        end else if (store_misaligned_i) begin
            event_cause = CauseStoreMisal;
            event_info  = 32'(mem_addr_i);
        end else begin
            trap_event = 1'b0;
        end
    end

    always_comb begin
        state_d          = state_q;
        cause_d          = cause_q;
        info_d           = info_q;
        tpc_d            = tpc_q;
        mepc_d           = mepc_q;
        jumpingToMtvec_o = 1'b0;
        squash_o         = 1'b0;
        stall_o          = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        mret_o           = 1'b0;

        // Combinational outputs must also read zero while reset is held.
        if (!rst) begin
            unique case (state_q)
                StIdle: begin
                    if (instr_valid_i) begin
                        if (trap_event) begin
                            squash_o = 1'b1;
                            stall_o  = 1'b1;
                            cause_d  = event_cause;
                            info_d   = event_info;
                            tpc_d    = 32'(pc_i);
                            state_d  = StCommit;
                        end else if (mret_i) begin
                            mret_o  = 1'b1;
                            stall_o = 1'b1;
                            mepc_d  = mepc_i;
                            state_d = StMretRedirect;
                        end
                    end
                end
                StCommit: begin
                    jumpingToMtvec_o = 1'b1;
                    stall_o          = 1'b1;
                    state_d          = StRedirect;
                end
                StRedirect: begin
                    stall_o          = 1'b1;
                    redirect_valid_o = 1'b1;
                    redirect_pc_o    = mtvec_aligned;
                    if (redirect_ready_i) begin
                        state_d = StIdle;
                    end
                end
                StMretRedirect: begin
                    stall_o          = 1'b1;
                    redirect_valid_o = 1'b1;
                    redirect_pc_o    = mepc_q;
                    if (redirect_ready_i) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cause_q <= '0;
            info_q  <= '0;
            tpc_q   <= '0;
            mepc_q  <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            info_q  <= info_d;
            tpc_q   <= tpc_d;
            mepc_q  <= mepc_d;
        end
    end

    assign excCause_o = cause_q;
    assign trapInfo_o = info_q;
    assign trapPc_o   = tpc_q;

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: directed scenarios plus randomized commits
// compared against a priority-table reference model.
module tb_trap_controller;

    logic        clk;
    logic        rst;
    logic        instr_valid_i;
    logic [31:0] pc_i;
    logic [31:0] instr_i;
    logic        instr_misaligned_i, illegal_instr_i, ebreak_i, ecall_i;
    logic        load_misaligned_i, store_misaligned_i;
    logic [31:0] branch_target_i, mem_addr_i;
    logic        mret_i, mtime_exc_i;
    logic [31:0] mtvec_i, mepc_i;
    logic        jumpingToMtvec_o;
    logic [31:0] excCause_o, trapInfo_o, trapPc_o;
    logic        squash_o, stall_o, redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic        redirect_ready_i;
    logic        mret_o;

    int errors = 0;
    int checks = 0;
    logic [31:0] last_cause = 0, last_info = 0, last_pc = 0;

    trap_controller #(.XLEN(32)) dut (
        .clk                (clk),
        .rst                (rst),
        .instr_valid_i      (instr_valid_i),
        .pc_i               (pc_i),
        .instr_i            (instr_i),
        .instr_misaligned_i (instr_misaligned_i),
        .illegal_instr_i    (illegal_instr_i),
        .ebreak_i           (ebreak_i),
        .ecall_i            (ecall_i),
        .load_misaligned_i  (load_misaligned_i),
        .store_misaligned_i (store_misaligned_i),
        .branch_target_i    (branch_target_i),
        .mem_addr_i         (mem_addr_i),
        .mret_i             (mret_i),
        .mtime_exc_i        (mtime_exc_i),
        .mtvec_i            (mtvec_i),
        .mepc_i             (mepc_i),
        .jumpingToMtvec_o   (jumpingToMtvec_o),
        .excCause_o         (excCause_o),
        .trapInfo_o         (trapInfo_o),
        .trapPc_o           (trapPc_o),
        .squash_o           (squash_o),
        .stall_o            (stall_o),
        .redirect_valid_o   (redirect_valid_o),
        .redirect_pc_o      (redirect_pc_o),
        .redirect_ready_i   (redirect_ready_i),
        .mret_o             (mret_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instr_valid_i = 0; pc_i = 0; instr_i = 0;
        instr_misaligned_i = 0; illegal_instr_i = 0; ebreak_i = 0; ecall_i = 0;
        load_misaligned_i = 0; store_misaligned_i = 0; branch_target_i = 0; mem_addr_i = 0;
        mret_i = 0; mtime_exc_i = 0; redirect_ready_i = 0;
    endtask

    // Garbage on every event input; mtvec stays put because the redirect target tracks it.
    task automatic scramble();
        instr_valid_i = 1; pc_i = $urandom; instr_i = $urandom;
        instr_misaligned_i = 1'($urandom); illegal_instr_i = 1'($urandom);
        ebreak_i = 1'($urandom); ecall_i = 1'($urandom);
        load_misaligned_i = 1'($urandom); store_misaligned_i = 1'($urandom);
        branch_target_i = $urandom; mem_addr_i = $urandom; mepc_i = $urandom;
        mret_i = 1'($urandom); mtime_exc_i = 1'($urandom);
    endtask

    // Reference: walk the priority table and take the first raised event.
    task automatic model(output logic is_trap, output logic is_mret,
                         output logic [31:0] cause, output logic [31:0] info);
        logic        flag [7];
        logic [31:0] ctab [7];
        logic [31:0] itab [7];
        flag = '{mtime_exc_i, instr_misaligned_i, illegal_instr_i, ebreak_i, ecall_i,
                 load_misaligned_i, store_misaligned_i};
        ctab = '{32'h8000_0007, 32'd0, 32'd2, 32'd3, 32'd11, 32'd4, 32'd6};
        itab = '{32'd0, branch_target_i, instr_i, pc_i, 32'd0, mem_addr_i, mem_addr_i};
        is_trap = 0; is_mret = 0; cause = 0; info = 0;
        if (instr_valid_i) begin
            for (int i = 0; i < 7; i++) begin
                if (flag[i] && !is_trap) begin
                    is_trap = 1; cause = ctab[i]; info = itab[i];
                end
            end
            if (!is_trap && mret_i) is_mret = 1;
        end
    endtask

    // Called with the trapping instruction already driven in cycle N.
    task automatic run_trap(input string tag, input logic [31:0] ec, input logic [31:0] ei,
                            input logic [31:0] ep, input int waits);
        logic [31:0] rpc;
        rpc = mtvec_i & 32'hFFFF_FFFC;
        #1;
        checks++; if ({squash_o, stall_o} !== 2'b11) begin errors++;
            $display("FAIL %s squash/stall in N got=%b exp=11", tag, {squash_o, stall_o}); end
        checks++; if ({jumpingToMtvec_o, mret_o, redirect_valid_o} !== 3'b000) begin errors++;
            $display("FAIL %s jump/mret/rvalid in N got=%b exp=000", tag,
                     {jumpingToMtvec_o, mret_o, redirect_valid_o}); end
        tick();
        scramble();
        #1;
        checks++; if ({jumpingToMtvec_o, stall_o, squash_o, mret_o} !== 4'b1100) begin
            errors++; $display("FAIL %s commit jump/stall/squash/mret got=%b exp=1100", tag,
                               {jumpingToMtvec_o, stall_o, squash_o, mret_o}); end
        checks++; if ({excCause_o, trapInfo_o, trapPc_o} !== {ec, ei, ep}) begin errors++;
            $display("FAIL %s record got=%h/%h/%h exp=%h/%h/%h", tag, excCause_o, trapInfo_o,
                     trapPc_o, ec, ei, ep); end
        tick();
        for (int i = 0; i <= waits; i++) begin
            scramble();
            redirect_ready_i = (i == waits);
            #1;
            checks++; if ({redirect_valid_o, stall_o, jumpingToMtvec_o, squash_o, mret_o}
                          !== 5'b11000 || redirect_pc_o !== rpc) begin errors++;
                $display("FAIL %s redirect[%0d] v/s/j/q/m=%b pc=%h exp 11000 pc=%h", tag, i,
                         {redirect_valid_o, stall_o, jumpingToMtvec_o, squash_o, mret_o},
                         redirect_pc_o, rpc); end
            tick();
        end
        idle_inputs();
        #1;
        checks++; if ({stall_o, redirect_valid_o, jumpingToMtvec_o} !== 3'b000 ||
                      {excCause_o, trapInfo_o, trapPc_o} !== {ec, ei, ep}) begin errors++;
            $display("FAIL %s back-to-idle s/v/j=%b cause=%h exp 000 cause=%h", tag,
                     {stall_o, redirect_valid_o, jumpingToMtvec_o}, excCause_o, ec); end
        last_cause = ec; last_info = ei; last_pc = ep;
    endtask

    task automatic run_mret(input string tag, input logic [31:0] epc, input int waits);
        #1;
        checks++; if ({mret_o, stall_o, squash_o, jumpingToMtvec_o, redirect_valid_o}
                      !== 5'b11000) begin errors++;
            $display("FAIL %s mret cycle m/s/q/j/v got=%b exp=11000", tag,
                     {mret_o, stall_o, squash_o, jumpingToMtvec_o, redirect_valid_o}); end
        tick();
        for (int i = 0; i <= waits; i++) begin
            scramble();
            redirect_ready_i = (i == waits);
            #1;
            checks++; if ({redirect_valid_o, stall_o, mret_o, squash_o, jumpingToMtvec_o}
                          !== 5'b11000 || redirect_pc_o !== epc) begin errors++;
                $display("FAIL %s mret redirect[%0d] v/s/m/q/j=%b pc=%h exp 11000 pc=%h", tag,
                         i, {redirect_valid_o, stall_o, mret_o, squash_o, jumpingToMtvec_o},
                         redirect_pc_o, epc); end
            tick();
        end
        idle_inputs();
        #1;
        checks++; if ({stall_o, redirect_valid_o, mret_o} !== 3'b000 ||
                      {excCause_o, trapInfo_o, trapPc_o} !== {last_cause, last_info, last_pc})
        begin errors++;
            $display("FAIL %s after mret s/v/m=%b cause=%h exp 000 cause=%h", tag,
                     {stall_o, redirect_valid_o, mret_o}, excCause_o, last_cause); end
    endtask

    task automatic run_none(input string tag);
        #1;
        checks++; if ({stall_o, squash_o, mret_o, jumpingToMtvec_o, redirect_valid_o} !== 5'b0
                      || excCause_o !== last_cause || trapPc_o !== last_pc) begin errors++;
            $display("FAIL %s no-event s/q/m/j/v=%b cause=%h exp 00000 cause=%h", tag,
                     {stall_o, squash_o, mret_o, jumpingToMtvec_o, redirect_valid_o},
                     excCause_o, last_cause); end
        tick();
        idle_inputs();
    endtask

    task automatic check_all_zero(input string tag);
        checks++; if ({jumpingToMtvec_o, squash_o, stall_o, redirect_valid_o, mret_o} !== 5'b0
                      || redirect_pc_o !== 0 || excCause_o !== 0 || trapInfo_o !== 0
                      || trapPc_o !== 0) begin errors++;
            $display("FAIL %s outputs under reset j/q/s/v/m=%b rpc=%h rec=%h/%h/%h exp all 0",
                     tag, {jumpingToMtvec_o, squash_o, stall_o, redirect_valid_o, mret_o},
                     redirect_pc_o, excCause_o, trapInfo_o, trapPc_o); end
    endtask

    task automatic test_reset();
        idle_inputs(); mtvec_i = 0; mepc_i = 0;
        rst = 1;
        #3;
        instr_valid_i = 1; illegal_instr_i = 1; mret_i = 1;
        #1;
        check_all_zero("reset");
        tick();
        idle_inputs();
        rst = 0;
        #1;
    endtask

    task automatic test_illegal();
        mtvec_i = 32'h201;
        instr_valid_i = 1; illegal_instr_i = 1; instr_i = 32'hFFFF_FFFF; pc_i = 32'h100;
        run_trap("illegal", 32'd2, 32'hFFFF_FFFF, 32'h100, 0);
    endtask

    task automatic test_timer_priority();
        instr_valid_i = 1; mtime_exc_i = 1; ecall_i = 1; pc_i = 32'h40;
        run_trap("timer_ecall", 32'h8000_0007, 32'd0, 32'h40, 1);
    endtask

    task automatic test_mret();
        mepc_i = 32'h84;
        instr_valid_i = 1; mret_i = 1;
        run_mret("mret_wait3", 32'h84, 3);
    endtask

    task automatic test_load_store();
        instr_valid_i = 1; load_misaligned_i = 1; store_misaligned_i = 1;
        mem_addr_i = 32'h1003; pc_i = 32'h2000;
        run_trap("load_store", 32'd4, 32'h1003, 32'h2000, 2);
    endtask

    task automatic test_invalid_ignored();
        instr_valid_i = 0; illegal_instr_i = 1; mtime_exc_i = 1; mret_i = 1; pc_i = 32'h55;
        run_none("valid_low");
    endtask

    task automatic test_reset_mid_redirect();
        mtvec_i = 32'h300;
        instr_valid_i = 1; ebreak_i = 1; pc_i = 32'h88;
        tick(); idle_inputs();
        tick();
        #1;
        checks++; if (redirect_valid_o !== 1'b1) begin errors++;
            $display("FAIL rst_mid reached redirect got=%b exp=1", redirect_valid_o); end
        rst = 1;
        #1;
        check_all_zero("rst_mid");
        tick(); tick();
        rst = 0;
        last_cause = 0; last_info = 0; last_pc = 0;
        tick();
        instr_valid_i = 1; ecall_i = 1; pc_i = 32'h44;
        run_trap("after_rst", 32'd11, 32'd0, 32'h44, 0);
    endtask

    task automatic test_random();
        logic        is_trap, is_mret;
        logic [31:0] ec, ei;
        for (int n = 0; n < 200; n++) begin
            mtvec_i = $urandom;
            mepc_i = $urandom;
            instr_valid_i = ($urandom_range(0, 3) != 0);
            pc_i = $urandom; instr_i = $urandom;
            branch_target_i = $urandom; mem_addr_i = $urandom;
            mtime_exc_i        = ($urandom_range(0, 7) == 0);
            instr_misaligned_i = ($urandom_range(0, 7) == 0);
            illegal_instr_i    = ($urandom_range(0, 7) == 0);
            ebreak_i           = ($urandom_range(0, 7) == 0);
            ecall_i            = ($urandom_range(0, 7) == 0);
            load_misaligned_i  = ($urandom_range(0, 7) == 0);
            store_misaligned_i = ($urandom_range(0, 7) == 0);
            mret_i             = ($urandom_range(0, 2) == 0);
            model(is_trap, is_mret, ec, ei);
            if (is_trap) run_trap("rand_trap", ec, ei, pc_i, $urandom_range(0, 3));
            else if (is_mret) run_mret("rand_mret", mepc_i, $urandom_range(0, 3));
            else run_none("rand_none");
        end
    endtask

    initial begin
        test_reset();
        test_illegal();
        test_timer_priority();
        test_mret();
        test_load_store();
        test_invalid_ignored();
        test_reset_mid_redirect();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
